overload_frame_detector: RTL and testbench
==========================================

// Module: overload_frame_detector
// PURPOSE
//  Receive-side counterpart of the CAN overload frame generator. Monitors the
//  sampled bus bit during intermission/EOF, recognises an overload flag, tracks
//  flag superposition, checks the 8-bit recessive delimiter and reports
//  completion or form error. Sits beside the bit-timing unit and feeds the
//  frame sequencer and error-confinement logic.
// PARAMETERS
//  FLAG_LEN      6   dominant bits forming the overload flag
//  DELIM_LEN     8   recessive bits forming the overload delimiter
//  MAX_DOMINANT  14  consecutive dominant bits tolerated before form error
// PORTS
//  clock                   in   1  system clock
//  reset_n                 in   1  asynchronous, active-low reset
//  enable                  in   1  0 = synchronous clear to IDLE, outputs to reset values
//  sample_point            in   1  one-cycle strobe; rx_bit is valid this cycle
//  rx_bit                  in   1  sampled bus level (0 = dominant)
//  intermission_active     in   1  high during the 3 intermission bits
//  intermission_bit        in   2  intermission bit index 0..2
//  eof_last_bit            in   1  high during the 7th EOF bit (receiver view)
//  clear_count             in   1  clear overload_count (start of a new data/remote frame)
//  overload_active         out  1  high from trigger until COMPLETE/ERROR
//  overload_detected       out  1  one-cycle pulse on trigger
//  overload_frame_received out  1  one-cycle pulse when the delimiter completes
//  form_error              out  1  one-cycle pulse on delimiter/flag violation
//  overload_count          out  2  overload frames since clear; saturates at 3
//  dominant_count          out  4  current consecutive-dominant run length
// BEHAVIOUR
//  - Reset and !enable: state=IDLE, all outputs 0, internal counters 0.
//  - State and counters advance only on clock edges with sample_point=1.
//    Pulses are registered: asserted the cycle after that edge, for 1 cycle.
//  - Trigger: rx_bit=0 AND (intermission_active with intermission_bit<=1, OR
//    eof_last_bit). Dominant at intermission_bit==2 is SOF; it is ignored.
//  - IDLE -> FLAG on trigger; dominant_count=1, overload_detected pulses.
//  - FLAG: rx_bit=0 -> dominant_count++; on reaching FLAG_LEN -> SUPERPOS.
//    rx_bit=1 before FLAG_LEN -> ERROR.
//  - SUPERPOS: rx_bit=0 -> dominant_count++; reaching MAX_DOMINANT -> ERROR.
//    rx_bit=1 -> DELIM, delim counter=1, dominant_count=0.
//  - DELIM: rx_bit=1 -> delim counter++; at DELIM_LEN -> COMPLETE.
//    rx_bit=0 -> ERROR.
//  - COMPLETE (1 cycle, no sample_point needed): overload_frame_received
//    pulse, overload_count += 1 saturating at 3, -> IDLE.
//  - ERROR (1 cycle): form_error pulse, count unchanged, -> IDLE.
//  - overload_active = state in {FLAG, SUPERPOS, DELIM}.
//  - dominant_count saturates at 15; it is 0 in IDLE.
//  - clear_count together with a COMPLETE increment: clear first, result = 1.
//  - A new trigger in the sample following COMPLETE is accepted normally.
//  - Reset/enable drop mid-frame: immediate IDLE; no completion or error pulse.
// TESTING
//  - Dominant at intermission_bit=0, then 6 dom + 8 rec -> detected pulse;
//    received pulse after the 14th bit; overload_count=1.
//  - 6 dom + 3 more dom (superposition) + 8 rec -> dominant_count peaks at 9;
//    received pulse; no form_error.
//  - Dominant only at intermission_bit=2 -> no trigger; overload_active stays 0.
//  - 6 dom + 3 rec + 1 dom -> form_error pulse, overload_count unchanged.
//  - 14 consecutive dom -> form_error pulse on the 14th sample.
//  - 4 back-to-back frames -> overload_count saturates at 3; clear_count gives 0.
//  - reset_n low in DELIM -> all outputs 0 asynchronously; IDLE on release.

Source files
------------

// File: rtl/overload_frame_detector.sv
// Receive-side CAN overload frame detector: recognises the overload flag during
// intermission/EOF, follows flag superposition and checks the recessive delimiter.
module overload_frame_detector #(
    parameter int unsigned FLAG_LEN     = 6,
    parameter int unsigned DELIM_LEN    = 8,
    parameter int unsigned MAX_DOMINANT = 14
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       intermission_active,
    input  logic [1:0] intermission_bit,
    input  logic       eof_last_bit,
    input  logic       clear_count,
    output logic       overload_active,
    output logic       overload_detected,
    output logic       overload_frame_received,
    output logic       form_error,
    output logic [1:0] overload_count,
    output logic [3:0] dominant_count
);

    localparam logic [3:0] FLAG_LEN_C  = 4'(FLAG_LEN);
    localparam logic [3:0] DELIM_LEN_C = 4'(DELIM_LEN);
    localparam logic [3:0] MAX_DOM_C   = 4'(MAX_DOMINANT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLAG,
        S_SUPERPOS,
        S_DELIM,
        S_COMPLETE,
        S_ERROR
    } state_t;

    state_t     state_q;
    logic       detected_q;
    logic       received_q;
    logic       form_error_q;
    logic [1:0] overload_count_q;
    logic [3:0] dominant_count_q;
    logic [3:0] delim_count_q;

    logic       trigger;
    logic [3:0] dom_inc;
    logic [3:0] delim_inc;
    logic [1:0] count_base;
    logic [1:0] count_d;

    always_comb begin
        // Dominant at intermission bit 2 is a start of frame, not an overload flag.
        trigger    = !rx_bit && ((intermission_active && (intermission_bit <= 2'd1)) || eof_last_bit);
        dom_inc    = (dominant_count_q == 4'hF) ? 4'hF : dominant_count_q + 4'd1;
        delim_inc  = delim_count_q + 4'd1;
        count_base = clear_count ? '0 : overload_count_q;
        count_d    = (count_base == 2'd3) ? 2'd3 : count_base + 2'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            detected_q       <= 1'b0;
            received_q       <= 1'b0;
            form_error_q     <= 1'b0;
            overload_count_q <= '0;
            dominant_count_q <= '0;
            delim_count_q    <= '0;
        end else if (!enable) begin
            state_q          <= S_IDLE;
            detected_q       <= 1'b0;
            received_q       <= 1'b0;
            form_error_q     <= 1'b0;
            overload_count_q <= '0;
            dominant_count_q <= '0;
            delim_count_q    <= '0;
        end else begin
            detected_q       <= 1'b0;
            received_q       <= 1'b0;
            form_error_q     <= 1'b0;
            overload_count_q <= count_base;
            unique case (state_q)
                // COMPLETE/ERROR last one cycle but still accept a trigger sample.
                S_IDLE, S_COMPLETE, S_ERROR: begin
                    state_q          <= S_IDLE;
                    dominant_count_q <= '0;
                    delim_count_q    <= '0;
                    if (sample_point && trigger) begin
                        state_q          <= S_FLAG;
                        dominant_count_q <= 4'd1;
                        detected_q       <= 1'b1;
                    end
                end
                S_FLAG: begin
                    if (sample_point) begin
                        if (!rx_bit) begin
                            dominant_count_q <= dom_inc;
                            if (dom_inc >= FLAG_LEN_C) state_q <= S_SUPERPOS;
                        end else begin
                            state_q      <= S_ERROR;
                            form_error_q <= 1'b1;
                        end
                    end
                end
                S_SUPERPOS: begin
                    if (sample_point) begin
                        if (!rx_bit) begin
                            dominant_count_q <= dom_inc;
                            if (dom_inc >= MAX_DOM_C) begin
                                state_q      <= S_ERROR;
                                form_error_q <= 1'b1;
                            end
                        end else begin
                            state_q          <= S_DELIM;
                            delim_count_q    <= 4'd1;
                            dominant_count_q <= '0;
                        end
                    end
                end
                S_DELIM: begin
                    if (sample_point) begin
                        if (rx_bit) begin
                            delim_count_q <= delim_inc;
                            if (delim_inc >= DELIM_LEN_C) begin
                                state_q          <= S_COMPLETE;
                                received_q       <= 1'b1;
                                overload_count_q <= count_d;
                            end
                        end else begin
                            state_q      <= S_ERROR;
                            form_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign overload_active         = (state_q == S_FLAG) || (state_q == S_SUPERPOS) || (state_q == S_DELIM);
    assign overload_detected       = detected_q;
    assign overload_frame_received = received_q;
    assign form_error              = form_error_q;
    assign overload_count          = overload_count_q;
    assign dominant_count          = dominant_count_q;

endmodule

// File: tb/tb_overload_frame_detector.sv
// Bench for overload_frame_detector: bit-level behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_overload_frame_detector;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       sample_point = 1'b0;
    logic       rx_bit = 1'b1;
    logic       intermission_active = 1'b0;
    logic [1:0] intermission_bit = 2'd0;
    logic       eof_last_bit = 1'b0;
    logic       clear_count = 1'b0;
    logic       overload_active;
    logic       overload_detected;
    logic       overload_frame_received;
    logic       form_error;
    logic [1:0] overload_count;
    logic [3:0] dominant_count;

    int asserts = 0;
    int failures = 0;

    overload_frame_detector #(.FLAG_LEN(6), .DELIM_LEN(8), .MAX_DOMINANT(14)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .sample_point(sample_point),
        .rx_bit(rx_bit),
        .intermission_active(intermission_active),
        .intermission_bit(intermission_bit),
        .eof_last_bit(eof_last_bit),
        .clear_count(clear_count),
        .overload_active(overload_active),
        .overload_detected(overload_detected),
        .overload_frame_received(overload_frame_received),
        .form_error(form_error),
        .overload_count(overload_count),
        .dominant_count(dominant_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an overload frame is a dominant run (>=6, error at 14) followed by
    // 8 recessive bits; any other pattern ends in a form error.
    int m_active, m_dom, m_rec, m_cnt, m_det, m_rcv, m_err;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n || !enable) begin
            m_active = 0; m_dom = 0; m_rec = 0; m_cnt = 0;
            m_det = 0; m_rcv = 0; m_err = 0;
        end else begin
            int base;
            m_det = 0; m_rcv = 0; m_err = 0;
            base = clear_count ? 0 : m_cnt;
            m_cnt = base;
            if (!m_active) begin
                m_dom = 0; m_rec = 0;
                if (sample_point && !rx_bit &&
                    ((intermission_active && intermission_bit < 2) || eof_last_bit)) begin
                    m_active = 1; m_dom = 1; m_det = 1;
                end
            end else if (sample_point) begin
                if (m_rec == 0) begin
                    if (!rx_bit) begin
                        m_dom = (m_dom < 15) ? m_dom + 1 : 15;
                        if (m_dom >= 14) begin m_active = 0; m_err = 1; end
                    end else if (m_dom < 6) begin
                        m_active = 0; m_err = 1;
                    end else begin
                        m_rec = 1; m_dom = 0;
                    end
                end else if (rx_bit) begin
                    m_rec++;
                    if (m_rec == 8) begin
                        m_active = 0; m_rcv = 1;
                        m_cnt = (base + 1 > 3) ? 3 : base + 1;
                    end
                end else begin
                    m_active = 0; m_err = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("active", int'(overload_active), m_active);
            chk("detected", int'(overload_detected), m_det);
            chk("received", int'(overload_frame_received), m_rcv);
            chk("form_error", int'(form_error), m_err);
            chk("count", int'(overload_count), m_cnt);
            chk("dom_count", int'(dominant_count), m_dom);
        end
    end

    int det_n, rcv_n, err_n, peak, act_seen;

    task automatic clr_stats();
        det_n = 0; rcv_n = 0; err_n = 0; peak = 0; act_seen = 0;
    endtask

    // One bit time: strobe on the first cycle, gap cycle after; called at posedge+1.
    task automatic send(input logic rx, input logic im, input logic [1:0] ib,
                        input logic eof, input logic clr);
        rx_bit = rx; intermission_active = im; intermission_bit = ib;
        eof_last_bit = eof; clear_count = clr; sample_point = 1'b1;
        @(posedge clock); #1;
        sample_point = 1'b0; clear_count = 1'b0;
        intermission_active = 1'b0; eof_last_bit = 1'b0; rx_bit = 1'b1;
        det_n += int'(overload_detected);
        rcv_n += int'(overload_frame_received);
        err_n += int'(form_error);
        if (int'(dominant_count) > peak) peak = int'(dominant_count);
        if (overload_active) act_seen = 1;
        @(posedge clock); #1;
    endtask

    task automatic frame(input int ndom, input int nrec, input logic use_eof, input logic clr_last);
        send(1'b0, !use_eof, 2'd0, use_eof, 1'b0);
        for (int i = 1; i < ndom; i++) send(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < nrec; i++)
            send(1'b1, 1'b0, 2'd0, 1'b0, clr_last && (i == nrec - 1));
    endtask

    task automatic pulse_clear();
        clear_count = 1'b1;
        @(posedge clock); #1;
        clear_count = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr_stats();
        #1;
        chk("rst_active", int'(overload_active), 0);
        chk("rst_count", int'(overload_count), 0);
        chk("rst_dom", int'(dominant_count), 0);
        #20 reset_n = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;

        // Basic frame triggered at intermission bit 0.
        clr_stats();
        frame(6, 8, 1'b0, 1'b0);
        chk("t1_detected", det_n, 1);
        chk("t1_received", rcv_n, 1);
        chk("t1_ferr", err_n, 0);
        chk("t1_count", int'(overload_count), 1);

        // Superposition: 9 dominant bits in total.
        clr_stats();
        frame(9, 8, 1'b1, 1'b0);
        chk("t2_peak", peak, 9);
        chk("t2_received", rcv_n, 1);
        chk("t2_ferr", err_n, 0);
        chk("t2_count", int'(overload_count), 2);

        // Dominant at intermission bit 2 is SOF.
        clr_stats();
        send(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        send(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t3_detected", det_n, 0);
        chk("t3_active", act_seen, 0);

        // Dominant inside the delimiter.
        clr_stats();
        frame(6, 3, 1'b1, 1'b0);
        send(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t4_ferr", err_n, 1);
        chk("t4_received", rcv_n, 0);
        chk("t4_count", int'(overload_count), 2);

        // Dominant run reaching 14.
        clr_stats();
        frame(13, 0, 1'b0, 1'b0);
        chk("t5_ferr_before", err_n, 0);
        send(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t5_ferr", err_n, 1);
        chk("t5_peak", peak, 14);

        // Back-to-back frames saturate the counter.
        pulse_clear();
        chk("t6_cleared", int'(overload_count), 0);
        clr_stats();
        for (int f = 0; f < 4; f++) frame(6, 8, 1'b1, 1'b0);
        chk("t6_received", rcv_n, 4);
        chk("t6_count", int'(overload_count), 3);
        pulse_clear();
        chk("t6_clear", int'(overload_count), 0);

        // Clear coinciding with a completion.
        frame(6, 8, 1'b1, 1'b0);
        chk("t7_count1", int'(overload_count), 1);
        frame(6, 8, 1'b1, 1'b1);
        chk("t7_clear_inc", int'(overload_count), 1);

        // Enable drop mid-frame.
        clr_stats();
        frame(4, 0, 1'b0, 1'b0);
        enable = 1'b0;
        @(posedge clock); #1;
        chk("t8_active", int'(overload_active), 0);
        chk("t8_dom", int'(dominant_count), 0);
        chk("t8_count", int'(overload_count), 0);
        enable = 1'b1;
        @(posedge clock); #1;
        chk("t8_ferr", err_n + int'(form_error), 0);

        // Asynchronous reset inside the delimiter.
        frame(6, 8, 1'b1, 1'b0);
        frame(6, 3, 1'b1, 1'b0);
        chk("t9_in_delim", int'(overload_active), 1);
        reset_n = 1'b0;
        #1;
        chk("t9_active", int'(overload_active), 0);
        chk("t9_count", int'(overload_count), 0);
        chk("t9_rcv", int'(overload_frame_received), 0);
        chk("t9_ferr", int'(form_error), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("t9_idle", int'(overload_active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
